// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - note codes, sample format and tone half-period table
package audio_pkg;

    localparam int NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] AMPLITUDE = 16'h2000;

    localparam int HALF_W = 7;

    // Frames per half tone period at Fs = 48828 Hz, rounded; entry 0 is the rest code.
    localparam logic [HALF_W-1:0] HALF_PERIOD [0:15] = '{
        7'd0,  7'd93, 7'd83, 7'd74, 7'd70, 7'd62, 7'd55, 7'd49,
        7'd47, 7'd42, 7'd37, 7'd35, 7'd31, 7'd28, 7'd25, 7'd23
    };

    function automatic logic [HALF_W-1:0] half_period(input logic [NOTE_W-1:0] n);
        return HALF_PERIOD[n];
    endfunction

endpackage

// File: rtl/i2s_serializer.sv
// rtl/i2s_serializer.sv - BCLK divider, slot counter and I2S shifter for one mono sample
module i2s_serializer
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int SLOTS    = 32
) (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                frame_start
);

    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int SLOT_W = $clog2(2 * SLOTS);
    localparam int LOC_W  = $clog2(SLOTS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * SLOTS - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_next;
    logic [LOC_W-1:0]  loc_next;
    logic              lr_next;
    logic              bit_next;

    // Values for the slot about to begin; they are loaded on the BCLK fall that starts it.
    always_comb begin
        slot_next = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        lr_next   = (slot_next >= SLOT_W'(SLOTS));
        loc_next  = lr_next ? LOC_W'(slot_next - SLOT_W'(SLOTS)) : LOC_W'(slot_next);
        bit_next  = 1'b0;
        if ((loc_next != '0) && (int'(loc_next) <= SAMPLE_W)) begin
            bit_next = sample[SAMPLE_W - int'(loc_next)];
        end
    end

    // First clock of slot 0: the low half of BCLK has just begun.
    assign frame_start = (div_cnt == '0) && !AUD_BCLK && (slot_cnt == '0);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            slot_cnt    <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            AUD_BCLK <= ~AUD_BCLK;
            if (AUD_BCLK) begin
                slot_cnt    <= slot_next;
                AUD_DACLRCK <= lr_next;
                AUD_DACDAT  <= bit_next;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_tone_i2s.sv
// rtl/note_tone_i2s.sv - note code to square-wave tone, streamed as 16-bit I2S to the codec DAC
module note_tone_i2s
    import audio_pkg::*;
#(
    parameter int                  BCLK_DIV  = 8,
    parameter int                  SLOTS     = 32,
    parameter logic [SAMPLE_W-1:0] AMP_LEVEL = AMPLITUDE
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NOTE_W-1:0] note,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              playing,
    output logic [NOTE_W-1:0] cur_note
);

    localparam logic [SAMPLE_W-1:0] AMP_NEG = ~AMP_LEVEL + 1'b1;

    logic [NOTE_W-1:0]   eff;
    logic [HALF_W-1:0]   half_cnt;
    logic [HALF_W-1:0]   half_last;
    logic                polarity;
    logic [SAMPLE_W-1:0] sample;
    logic                frame_start;

    assign eff       = enable ? note : NOTE_REST;
    assign half_last = half_period(eff) - 1'b1;

    // One tone step per frame; polarity 1 means the positive level.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cur_note <= NOTE_REST;
            playing  <= 1'b0;
            half_cnt <= '0;
            polarity <= 1'b1;
            sample   <= '0;
        end else if (frame_start) begin
            cur_note <= eff;
            playing  <= (eff != NOTE_REST);
            if (eff == NOTE_REST) begin
                sample   <= '0;
                half_cnt <= '0;
                polarity <= 1'b1;
            end else if (eff != cur_note) begin
                sample   <= AMP_LEVEL;
                half_cnt <= '0;
                polarity <= 1'b1;
            end else begin
                sample <= polarity ? AMP_LEVEL : AMP_NEG;
                if (half_cnt == half_last) begin
                    half_cnt <= '0;
                    polarity <= ~polarity;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end
        end
    end

    i2s_serializer #(
        .BCLK_DIV (BCLK_DIV),
        .SLOTS    (SLOTS)
    ) u_ser (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .sample      (sample),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .frame_start (frame_start)
    );

endmodule

// File: tb/tb_note_tone_i2s.sv
// tb/tb_note_tone_i2s.sv - directed self-checking bench for note_tone_i2s
module tb_note_tone_i2s;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] note;
    logic       bclk;
    logic       lrck;
    logic       dat;
    logic       playing;
    logic [3:0] cur_note;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
        logic        zero_bad;
        logic        lr_bad;
        logic        play;
        logic [3:0]  cur;
    } frame_t;

    frame_t      fq[$];
    frame_t      acc;
    logic [5:0]  bslot = '0;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b0;
    int          cyc = 0;
    int          last_lr = 0;
    int          lr_period = 0;

    note_tone_i2s dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .note        (note),
        .AUD_BCLK    (bclk),
        .AUD_DACLRCK (lrck),
        .AUD_DACDAT  (dat),
        .playing     (playing),
        .cur_note    (cur_note)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent codec-side receiver: reads LRCK/DACDAT on each BCLK rise.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            bslot     = '0;
            acc       = '0;
            prev_bclk = 1'b0;
            prev_lr   = 1'b0;
        end else begin
            if (lrck && !prev_lr) begin
                lr_period = cyc - last_lr;
                last_lr   = cyc;
            end
            prev_lr = lrck;
            if (bclk && !prev_bclk) begin
                if (lrck != bslot[5]) acc.lr_bad = 1'b1;
                if (bslot[4:0] >= 5'd1 && bslot[4:0] <= 5'd16) begin
                    if (bslot[5]) acc.right = {acc.right[14:0], dat};
                    else          acc.left  = {acc.left[14:0], dat};
                end else if (dat) begin
                    acc.zero_bad = 1'b1;
                end
                if (bslot == 6'd63) begin
                    acc.play = playing;
                    acc.cur  = cur_note;
                    fq.push_back(acc);
                    acc = '0;
                end
                bslot = bslot + 6'd1;
            end
            prev_bclk = bclk;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_frame(output frame_t f);
        int n;
        n = 0;
        while (fq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (fq.size() == 0) begin
            check("frame_wait", fq.size(), 1);
            f = '0;
        end else begin
            f = fq.pop_front();
        end
    endtask

    task automatic check_frame(input string tag, input frame_t f, input logic [15:0] s,
                               input logic [3:0] cn, input logic pl);
        check({tag, "_left"}, f.left, s);
        check({tag, "_right"}, f.right, s);
        check({tag, "_zero_slots"}, f.zero_bad, 0);
        check({tag, "_lrck"}, f.lr_bad, 0);
        check({tag, "_cur_note"}, f.cur, cn);
        check({tag, "_playing"}, f.play, pl);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_lrck"}, lrck, 0);
        check({tag, "_dat"}, dat, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_cur_note"}, cur_note, 0);
    endtask

    initial begin
        frame_t      f;
        logic [15:0] s [0:48];
        int          n;
        int          i1;
        int          i2;

        rst_n  = 1'b0;
        enable = 1'b1;
        note   = 4'd6;
        repeat (50) @(negedge clk);
        check_idle("reset");

        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bclk && n < 100);
        check("first_bclk_rise", n, 8);

        for (int k = 0; k < 3; k++) begin
            get_frame(f);
            check_frame("note6", f, 16'h2000, 4'd6, 1'b1);
        end
        check("frame_period", lr_period, 1024);

        repeat (400) @(negedge clk);
        note = 4'd15;
        get_frame(f);
        check_frame("pre_change", f, 16'h2000, 4'd6, 1'b1);
        for (int k = 0; k < 49; k++) begin
            get_frame(f);
            s[k] = f.left;
            if (k == 0) check_frame("note15_first", f, 16'h2000, 4'd15, 1'b1);
        end
        i1 = 49;
        for (int k = 48; k >= 0; k--) if (s[k] != 16'h2000) i1 = k;
        i2 = 49;
        for (int k = 48; k > i1; k--) if (s[k] == 16'h2000) i2 = k;
        check("note15_neg_level", (i1 < 49) ? s[i1] : 16'h0, 16'hE000);
        check("note15_neg_run", i2 - i1, 23);

        note = 4'd0;
        get_frame(f);
        check_frame("rest", f, 16'h0000, 4'd0, 1'b0);
        enable = 1'b0;
        note   = 4'd3;
        get_frame(f);
        check_frame("disabled", f, 16'h0000, 4'd0, 1'b0);

        enable = 1'b1;
        note   = 4'd6;
        get_frame(f);
        check_frame("resume6", f, 16'h2000, 4'd6, 1'b1);
        repeat (300) @(negedge clk);
        note = 4'd4;
        repeat (3) @(negedge clk);
        note = 4'd6;
        get_frame(f);
        check_frame("glitch_a", f, 16'h2000, 4'd6, 1'b1);
        get_frame(f);
        check_frame("glitch_b", f, 16'h2000, 4'd6, 1'b1);

        n = 0;
        while (bslot != 6'd10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("slot10_reached", bslot, 10);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        fq.delete();
        get_frame(f);
        check_frame("post_reset", f, 16'h2000, 4'd6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
